data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder that serves load/store requests from the processor's memory stage over a valid/ready handshake. It replaces the zero-latency data memory with a slave that inserts a fixed number of wait states. It supports word reads, word writes and single-byte writes, and flags bad accesses with an error response. It sits between the pipelined or stalled CPU datapath and the backing storage array.

## Interface
Parameters:
- ADDR_WIDTH, 10: number of word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: wait cycles from request acceptance to response; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and all memory words to zero.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data; a byte write uses bits [7:0].
- req_word_we  in  1  word write.
- req_byte_we  in  1  byte write.
- resp_valid  out  1  response present.
- resp_rdata  out  32  word at the aligned address, read after any write is applied.
- resp_error  out  1  the request was rejected and memory is unchanged.
- resp_ready  in  1  requester accepts the response.

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- Output reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
- Read: a request with neither write enable set. It returns the full word at {req_addr[ADDR_WIDTH+1:2]}. Any value of req_addr[1:0] is legal for a read; the CPU does byte selection.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, word_we and byte_we, and compute the error flag.
  - Load the counter with LATENCY-1 and go to WAIT.
- Error conditions, any of:
  - req_word_we and req_byte_we both set.
  - req_word_we with req_addr[1:0]≠0.
  - req_addr[31:ADDR_WIDTH+2]≠0.
- WAIT:
  - req_ready=0.
  - When the counter is 0:
    - Perform the access if there is no error.
    - Word write: store all 32 bits.
    - Byte write: store wdata[7:0] into lane addr[1:0]. Lane 0 is bits [7:0] and lane 3 is bits [31:24] (little-endian). The other lanes are unchanged.
    - Capture resp_rdata, or 0 on error, and resp_error.
    - Go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_error are held stable until resp_valid && resp_ready, then go to IDLE.
  - resp_valid stays high indefinitely while resp_ready=0.
- Memory is written only in the last WAIT cycle. Requests are never accepted outside IDLE, so there is no read-during-write hazard.
- Request inputs are ignored outside IDLE. Their values may change after the accept edge without effect.
- resp_rdata/resp_error keep their last value outside RESP. Checkers sample them only when resp_valid=1.

## Timing
- Accept at edge N. resp_valid rises after edge N+LATENCY; the memory write commits at that same edge.
- Response handshake at edge M returns to IDLE. req_ready is high after M, and the earliest next accept is edge M+1.
- Best-case throughput: one request per LATENCY+2 cycles.
- req_ready and resp_valid are decoded from the state register only, with no combinational path from inputs.
- Reset asserted mid-operation, in any state:
  - Return to IDLE immediately, without waiting for a clock edge.
  - Drop the pending request with no write.
  - Zero the array.
  - Deassert resp_valid.
- LATENCY=1: WAIT lasts exactly one cycle.

## Structure
- Shared package mem_pkg:
  - State encoding constants: IDLE, WAIT, RESP.
  - Counter width: 4 bits.
  - Lane-index constants.
- Sub-module mem_array: 2^ADDR_WIDTH×32 storage.
  - Asynchronous read, synchronous write.
  - 4-bit byte-lane write mask and asynchronous reset clear.
- The top level holds the FSM, the counter, the request latch, the error check and the lane-mask generation.

## Test plan
- Reset, then read addr 0x00000010 with LATENCY=2: resp_valid after 2 edges, rdata=0x00000000, error=0.
- Word write 0xDEADBEEF to 0x20, then read 0x23: rdata=0xDEADBEEF. The write response rdata is also 0xDEADBEEF.
- Byte write 0x55 to 0x22 over word 0xDEADBEEF: rdata=0xDE55BEEF; a read of 0x20 confirms.
- Error cases, each giving error=1, rdata=0 and a subsequent read showing unchanged memory:
  - Word write to 0x21.
  - Word write to 0x1000 with ADDR_WIDTH=10.
  - Both write enables set.
- Hold resp_ready=0 for 5 cycles: resp_valid and rdata stay stable and req_ready=0 throughout. On release, idle one cycle, then accept the next request.
- Reset asserted in WAIT of a word write of 0x12345678 to 0x40: outputs return to their reset values without a clock edge, and a later read of 0x40 returns 0. Repeat all tests with LATENCY=1 and LATENCY=15.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// FSM encoding, wait counter width and byte-lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W  = 4;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  function automatic logic [LANES-1:0] lane_mask(
    input logic       word_we,
    input logic       byte_we,
    input logic [1:0] lane
  );
    logic [LANES-1:0] m;
    m = '0;
    if (word_we) begin
      m = '1;
    end else if (byte_we) begin
      case (lane)
        LANE0:   m = 4'b0001;
        LANE1:   m = 4'b0010;
        LANE2:   m = 4'b0100;
        LANE3:   m = 4'b1000;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] bit_mask(
    input logic [LANES-1:0] m
  );
    return {{LANE_W{m[3]}}, {LANE_W{m[2]}},
            {LANE_W{m[1]}}, {LANE_W{m[0]}}};
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word storage with asynchronous read, byte-masked synchronous write
// and an asynchronous clear of every word.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [LANES-1:0]      be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] bm;

  assign bm = bit_mask(be_i);

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic sel;
    assign sel = we_i && (addr_i == ADDR_WIDTH'(w));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        mem_q[w] <= '0;
      end else if (sel) begin
        mem_q[w] <= (mem_q[w] & ~bm) | (wdata_i & bm);
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles,
// applies the write, then holds the response until it is taken.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_word_we,
  input  logic        req_byte_we,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  input  logic        resp_ready
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [31:0]           wdata_q;
  logic                  word_we_q;
  logic                  byte_we_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic                  rerr_q;

  logic                  req_err;
  logic                  accept;
  logic                  last;
  logic                  hs;
  logic                  mem_we;
  logic [LANES-1:0]      mask;
  logic [31:0]           bm;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic [31:0]           merged;

  assign req_err =
    (req_word_we && req_byte_we) ||
    (req_word_we && (req_addr[1:0] != 2'b00)) ||
    ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  assign accept = (state_q == IDLE) && req_valid;
  assign last   = (state_q == WAIT) && (cnt_q == '0);
  assign hs     = (state_q == RESP) && resp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (last) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready  = 1'b1;
      WAIT:    req_ready  = 1'b0;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      word_we_q <= 1'b0;
      byte_we_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      addr_q    <= req_addr[ADDR_WIDTH+1:2];
      lane_q    <= req_addr[1:0];
      wdata_q   <= req_wdata;
      word_we_q <= req_word_we;
      byte_we_q <= req_byte_we;
      err_q     <= req_err;
    end
  end

  // Byte data is replicated so the lane mask alone picks its position.
  assign mask      = lane_mask(word_we_q, byte_we_q, lane_q);
  assign bm        = bit_mask(mask);
  assign mem_wdata = byte_we_q ? {4{wdata_q[7:0]}} : wdata_q;
  assign merged    = (mem_wdata & bm) | (mem_rdata & ~bm);
  assign mem_we    = last && !err_q &&
                     (word_we_q || byte_we_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else if (last) begin
      rdata_q <= err_q ? 32'd0 : merged;
      rerr_q  <= err_q;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_error = rerr_q;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .we_i   (mem_we),
    .be_i   (mask),
    .addr_i (addr_q),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at LATENCY 2, 1 and 15 against
// a timeline-and-array model of the load/store responder.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_word_we[3];
  logic        req_byte_we[3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];
  logic        resp_ready [3];

  logic        exp_ready [3];
  logic        exp_valid [3];
  logic [31:0] exp_rdata [3];
  logic        exp_err   [3];

  logic [31:0] mm [3][1024];

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_word_we(req_word_we[0]), .req_byte_we(req_byte_we[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_error(resp_error[0]), .resp_ready(resp_ready[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_word_we(req_word_we[1]), .req_byte_we(req_byte_we[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_error(resp_error[1]), .resp_ready(resp_ready[1])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) u_l15 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_word_we(req_word_we[2]), .req_byte_we(req_byte_we[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .resp_error(resp_error[2]), .resp_ready(resp_ready[2])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s lat=%0d actual=%h required=%h t=%0t",
               nm, lat_of(k), act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 1024; i++)
        mm[k][i] = 32'd0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk("req_ready", k, 32'(req_ready[k]),
            32'(exp_ready[k]));
        chk("resp_valid", k, 32'(resp_valid[k]),
            32'(exp_valid[k]));
        if (exp_valid[k] && resp_valid[k]) begin
          chk("resp_rdata", k, resp_rdata[k], exp_rdata[k]);
          chk("resp_error", k, 32'(resp_error[k]),
              32'(exp_err[k]));
        end
      end
    end
  end

  task automatic scramble(input int k);
    req_valid[k]   = 1'($urandom);
    req_addr[k]    = $urandom;
    req_wdata[k]   = $urandom;
    req_word_we[k] = 1'($urandom);
    req_byte_we[k] = 1'($urandom);
    resp_ready[k]  = 1'($urandom);
  endtask

  task automatic run_op(input int k, input bit ww, input bit bw,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int hold, input bit lit,
                        input logic [31:0] lrd, input bit lerr,
                        input string nm);
    bit          er;
    int          idx;
    int          sh;
    logic [31:0] w;
    req_addr[k]    = a;
    req_wdata[k]   = wd;
    req_word_we[k] = ww;
    req_byte_we[k] = bw;
    req_valid[k]   = 1'b1;
    resp_ready[k]  = 1'($urandom);
    @(posedge clk); #1;
    scramble(k);
    exp_ready[k] = 1'b0;
    exp_valid[k] = 1'b0;
    er = (ww && bw) || (ww && a[1:0] != 2'd0) ||
         ((a >> 12) != 32'd0);
    idx = int'(a[11:2]);
    if (!er) begin
      w = mm[k][idx];
      if (ww) begin
        w = wd;
      end else if (bw) begin
        sh = int'(a[1:0]) * 8;
        w = (w & ~(32'hFF << sh)) | ({24'd0, wd[7:0]} << sh);
      end
      mm[k][idx] = w;
    end
    repeat (lat_of(k)) begin
      @(posedge clk); #1;
      scramble(k);
    end
    resp_ready[k] = 1'b0;
    exp_valid[k]  = 1'b1;
    exp_rdata[k]  = er ? 32'd0 : mm[k][idx];
    exp_err[k]    = er;
    if (lit) begin
      chk({nm, "_valid"}, k, 32'(resp_valid[k]), 32'd1);
      chk({nm, "_rdata"}, k, resp_rdata[k], lrd);
      chk({nm, "_error"}, k, 32'(resp_error[k]), 32'(lerr));
    end
    repeat (hold) begin
      @(posedge clk); #1;
      req_valid[k] = 1'($urandom);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b0;
    exp_valid[k]  = 1'b0;
    exp_ready[k]  = 1'b1;
  endtask

  task automatic reset_mid(input int k);
    req_addr[k]    = 32'h40;
    req_wdata[k]   = 32'h12345678;
    req_word_we[k] = 1'b1;
    req_byte_we[k] = 1'b0;
    req_valid[k]   = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    exp_ready[k] = 1'b0;
    exp_valid[k] = 1'b0;
    #1;
    chk("wait_ready", k, 32'(req_ready[k]), 32'd0);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_ready[j] = 1'b1;
      exp_valid[j] = 1'b0;
    end
    clear_model();
    #1;
    chk("rst_ready", k, 32'(req_ready[k]), 32'd1);
    chk("rst_valid", k, 32'(resp_valid[k]), 32'd0);
    chk("rst_rdata", k, resp_rdata[k], 32'd0);
    chk("rst_error", k, 32'(resp_error[k]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic directed(input int k);
    run_op(k, 0, 0, 32'h10, 32'h0, 0, 1, 32'h0, 0, "rd10");
    run_op(k, 1, 0, 32'h20, 32'hDEADBEEF, 0, 1,
           32'hDEADBEEF, 0, "ww20");
    run_op(k, 0, 0, 32'h23, 32'h0, 0, 1,
           32'hDEADBEEF, 0, "rd23");
    run_op(k, 0, 1, 32'h22, 32'hAAAAAA55, 0, 1,
           32'hDE55BEEF, 0, "bw22");
    run_op(k, 0, 0, 32'h20, 32'h0, 0, 1,
           32'hDE55BEEF, 0, "rd20");
    run_op(k, 1, 0, 32'h21, 32'h11111111, 0, 1,
           32'h0, 1, "ww21");
    run_op(k, 0, 0, 32'h20, 32'h0, 0, 1,
           32'hDE55BEEF, 0, "rd20b");
    run_op(k, 1, 0, 32'h1000, 32'hCAFEF00D, 0, 1,
           32'h0, 1, "ww1000");
    run_op(k, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0, 0, "rd0");
    run_op(k, 1, 1, 32'h20, 32'h01020304, 0, 1,
           32'h0, 1, "both");
    run_op(k, 0, 0, 32'h20, 32'h0, 5, 1,
           32'hDE55BEEF, 0, "hold5");
    run_op(k, 0, 0, 32'h24, 32'h0, 0, 1, 32'h0, 0, "b2b");
    reset_mid(k);
    run_op(k, 0, 0, 32'h40, 32'h0, 0, 1, 32'h0, 0, "rd40");
    run_op(k, 0, 0, 32'h20, 32'h0, 0, 1, 32'h0, 0, "rd20z");
  endtask

  task automatic random_ops(input int k, input int n);
    int          t;
    bit          ww;
    bit          bw;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      t  = $urandom_range(0, 9);
      ww = (t == 4 || t == 5 || t == 8);
      bw = (t == 6 || t == 7 || t == 8);
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ((t == 4 || t == 5) && $urandom_range(0, 3) != 0)
        a[1:0] = 2'd0;
      if (t == 9) begin
        ww = 1'($urandom);
        a  = a | (32'd1 << $urandom_range(12, 31));
      end
      run_op(k, ww, bw, a, $urandom, $urandom_range(0, 3),
             0, 32'h0, 0, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]   = 1'b0;
      req_addr[k]    = 32'd0;
      req_wdata[k]   = 32'd0;
      req_word_we[k] = 1'b0;
      req_byte_we[k] = 1'b0;
      resp_ready[k]  = 1'b0;
      exp_ready[k]   = 1'b1;
      exp_valid[k]   = 1'b0;
      exp_rdata[k]   = 32'd0;
      exp_err[k]     = 1'b0;
    end
    clear_model();
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("init_ready", k, 32'(req_ready[k]), 32'd1);
      chk("init_valid", k, 32'(resp_valid[k]), 32'd0);
      chk("init_rdata", k, resp_rdata[k], 32'd0);
      chk("init_error", k, 32'(resp_error[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      directed(k);
      random_ops(k, 40);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
